// File: rtl/result_pkg.sv
// Purpose: shared types, constants and helpers for the reaction-result statistics block.
// Contents:
//   RESULT_W    - default tick width of one result
//   result_t    - one result, RESULT_W bits wide
//   RESULT_NONE - all-ones value meaning "no result yet"
//   clog2()     - ceiling log2, usable in constant expressions
package result_pkg;

    localparam int unsigned RESULT_W = 28;

    typedef logic [RESULT_W-1:0] result_t;

    localparam result_t RESULT_NONE = '1;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/result_stats_if.sv
// Purpose: bundles the strobe inputs, the history read port and the statistics
// outputs of result_stats.
// Modports:
//   master - producer/consumer side (drives strobes and i_rd_idx, reads statistics)
//   slave  - result_stats side
interface result_stats_if #(
    parameter int unsigned W     = result_pkg::RESULT_W,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 16
);
    localparam int unsigned AW = result_pkg::clog2(DEPTH);

    logic             i_valid;
    logic [W-1:0]     i_ticks;
    logic             i_false_start;
    logic             i_clear;
    logic [AW-1:0]    i_rd_idx;
    logic [W-1:0]     o_rd_ticks;
    logic [W-1:0]     o_last;
    logic [W-1:0]     o_best;
    logic [W-1:0]     o_worst;
    logic [W-1:0]     o_avg;
    logic             o_avg_valid;
    logic [CNT_W-1:0] o_count;
    logic [CNT_W-1:0] o_false_count;

    modport master (
        output i_valid, i_ticks, i_false_start, i_clear, i_rd_idx,
        input  o_rd_ticks, o_last, o_best, o_worst, o_avg, o_avg_valid,
               o_count, o_false_count
    );

    modport slave (
        input  i_valid, i_ticks, i_false_start, i_clear, i_rd_idx,
        output o_rd_ticks, o_last, o_best, o_worst, o_avg, o_avg_valid,
               o_count, o_false_count
    );

endinterface

// File: rtl/result_ring.sv
// Purpose: DEPTH-entry history ring of accepted results with a running window sum
// and a registered, age-addressed read port.
// Ports:
//   i_clk_50m, i_rst_n - clock, synchronous active-low reset
//   i_clear            - wipe ring, pointer, fill level and sum
//   i_wr, i_data       - write one accepted result
//   i_rd_idx           - age to read (0 = newest)
//   o_rd_ticks         - entry at i_rd_idx, 1-cycle latency, 0 beyond fill level
//   o_sum              - sum of the entries currently in the window
//   o_full             - DEPTH results have been written since reset/clear
module result_ring
    import result_pkg::*;
#(
    parameter int unsigned W     = RESULT_W,
    parameter int unsigned DEPTH = 8
) (
    input  logic                          i_clk_50m,
    input  logic                          i_rst_n,
    input  logic                          i_clear,
    input  logic                          i_wr,
    input  logic [W-1:0]                  i_data,
    input  logic [clog2(DEPTH)-1:0]       i_rd_idx,
    output logic [W-1:0]                  o_rd_ticks,
    output logic [W+clog2(DEPTH)-1:0]     o_sum,
    output logic                          o_full
);

    localparam int unsigned AW = clog2(DEPTH);
    localparam int unsigned SW = W + AW;
    localparam int unsigned FW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [FW-1:0] fill_q, fill_d;
    logic [SW-1:0] sum_q, sum_d;
    logic          full_q, full_d;
    logic [W-1:0]  rd_q, rd_d;
    logic [AW-1:0] rd_addr;
    logic [W-1:0]  evicted;

    // Newest entry sits just behind wptr; pointer arithmetic wraps since DEPTH = 2^AW.
    always_comb begin
        rd_addr = wptr_q - AW'(1) - i_rd_idx;
        evicted = full_q ? mem_q[wptr_q] : '0;
    end

    // Next-state: read uses pre-write contents; clear overrides any write.
    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        fill_d = fill_q;
        sum_d  = sum_q;
        full_d = full_q;
        rd_d   = (FW'(i_rd_idx) < fill_q) ? mem_q[rd_addr] : '0;
        if (i_clear) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_d[i] = '0;
            end
            wptr_d = '0;
            fill_d = '0;
            sum_d  = '0;
            full_d = 1'b0;
            rd_d   = '0;
        end else if (i_wr) begin
            mem_d[wptr_q] = i_data;
            wptr_d        = wptr_q + AW'(1);
            if (!full_q) begin
                fill_d = fill_q + FW'(1);
            end
            full_d = full_q || (fill_q == FW'(DEPTH - 1));
            sum_d  = sum_q + SW'(i_data) - SW'(evicted);
        end
    end

    // State registers.
    always_ff @(posedge i_clk_50m) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wptr_q <= '0;
            fill_q <= '0;
            sum_q  <= '0;
            full_q <= 1'b0;
            rd_q   <= '0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            fill_q <= fill_d;
            sum_q  <= sum_d;
            full_q <= full_d;
            rd_q   <= rd_d;
        end
    end

    assign o_rd_ticks = rd_q;
    assign o_sum      = sum_q;
    assign o_full     = full_q;

endmodule

// File: rtl/result_stats.sv
// Purpose: reaction-result statistics: last/best/worst, windowed average,
// attempt and false-start counters, and a history read port.
// Ports:
//   i_clk_50m - 50 MHz system clock
//   i_rst_n   - synchronous active-low reset
//   sif       - result_stats_if.slave: strobes (i_valid/i_ticks, i_false_start,
//               i_clear), history read (i_rd_idx/o_rd_ticks) and statistics outputs
module result_stats
    import result_pkg::*;
#(
    parameter int unsigned W     = RESULT_W,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic           i_clk_50m,
    input  logic           i_rst_n,
    result_stats_if.slave  sif
);

    localparam int unsigned AW = clog2(DEPTH);
    localparam int unsigned SW = W + AW;

    logic             accept;
    logic             false_start;
    logic [SW-1:0]    ring_sum;
    logic             ring_full;

    logic [W-1:0]     last_q, last_d;
    logic [W-1:0]     best_q, best_d;
    logic [W-1:0]     worst_q, worst_d;
    logic [W-1:0]     avg_q, avg_d;
    logic             avg_valid_q, avg_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] fcnt_q, fcnt_d;

    // Strobe arbitration: clear beats false start beats valid.
    assign false_start = !sif.i_clear && sif.i_false_start;
    assign accept      = !sif.i_clear && !sif.i_false_start && sif.i_valid;

    result_ring #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_ring (
        .i_clk_50m  (i_clk_50m),
        .i_rst_n    (i_rst_n),
        .i_clear    (sif.i_clear),
        .i_wr       (accept),
        .i_data     (sif.i_ticks),
        .i_rd_idx   (sif.i_rd_idx),
        .o_rd_ticks (sif.o_rd_ticks),
        .o_sum      (ring_sum),
        .o_full     (ring_full)
    );

    // Next-state for the scalar statistics.
    always_comb begin
        last_d      = last_q;
        best_d      = best_q;
        worst_d     = worst_q;
        cnt_d       = cnt_q;
        fcnt_d      = fcnt_q;
        // Average trails the ring sum by one register stage.
        avg_d       = ring_full ? W'(ring_sum >> AW) : '0;
        avg_valid_d = ring_full;
        if (sif.i_clear) begin
            last_d      = {W{1'b1}};
            best_d      = {W{1'b1}};
            worst_d     = '0;
            cnt_d       = '0;
            fcnt_d      = '0;
            avg_d       = '0;
            avg_valid_d = 1'b0;
        end else if (false_start) begin
            if (fcnt_q != {CNT_W{1'b1}}) begin
                fcnt_d = fcnt_q + CNT_W'(1);
            end
        end else if (accept) begin
            last_d = sif.i_ticks;
            if (sif.i_ticks < best_q) begin
                best_d = sif.i_ticks;
            end
            if (sif.i_ticks > worst_q) begin
                worst_d = sif.i_ticks;
            end
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers.
    always_ff @(posedge i_clk_50m) begin
        if (!i_rst_n) begin
            last_q      <= {W{1'b1}};
            best_q      <= {W{1'b1}};
            worst_q     <= '0;
            cnt_q       <= '0;
            fcnt_q      <= '0;
            avg_q       <= '0;
            avg_valid_q <= 1'b0;
        end else begin
            last_q      <= last_d;
            best_q      <= best_d;
            worst_q     <= worst_d;
            cnt_q       <= cnt_d;
            fcnt_q      <= fcnt_d;
            avg_q       <= avg_d;
            avg_valid_q <= avg_valid_d;
        end
    end

    assign sif.o_last        = last_q;
    assign sif.o_best        = best_q;
    assign sif.o_worst       = worst_q;
    assign sif.o_avg         = avg_q;
    assign sif.o_avg_valid   = avg_valid_q;
    assign sif.o_count       = cnt_q;
    assign sif.o_false_count = fcnt_q;

endmodule

// File: doc/result_stats.md
Name: result_stats

Overview:
- Parametrised successor to the single last/best result latch in the reaction tester top level.
- Records every measured reaction result into a DEPTH-entry history ring.
- Maintains last, best and worst results, a running average over the full window, an attempt count and a false-start count, plus a history read port.
- Sits in the i_clk_50m domain between the reaction FSM and state_transfer, which reads its outputs for display.

Parameters:
- W, 28, tick width of one result.
- DEPTH, 8, history entries; must be a power of two, >= 2.
- CNT_W, 16, width of the attempt and false-start counters.

Ports:
- i_clk_50m  in  1  system clock, 50 MHz.
- i_rst_n  in  1  reset; synchronous, active-low.
- i_valid  in  1  single-cycle strobe: i_ticks holds a completed measurement.
- i_ticks  in  W  measured reaction ticks.
- i_false_start  in  1  single-cycle strobe: button pressed before the stimulus.
- i_clear  in  1  single-cycle strobe: wipe all statistics (same effect as reset).
- i_rd_idx  in  $clog2(DEPTH)  history age to read; 0 = most recent.
- o_rd_ticks  out  W  history entry at i_rd_idx.
- o_last  out  W  most recent accepted result.
- o_best  out  W  minimum accepted result.
- o_worst  out  W  maximum accepted result.
- o_avg  out  W  mean of the last DEPTH results.
- o_avg_valid  out  1  high once DEPTH results have been accepted.
- o_count  out  CNT_W  accepted results, saturating.
- o_false_count  out  CNT_W  false starts, saturating.

Behaviour:
- All state is on i_clk_50m. Reset is synchronous: it is sampled only on the rising edge while i_rst_n = 0.
- Reset / clear values:
  - o_last = all-ones; o_best = all-ones; o_worst = 0.
  - o_avg = 0; o_avg_valid = 0; o_count = 0; o_false_count = 0.
  - Every ring entry = 0; write pointer = 0; fill level = 0; running sum = 0.
- Priority each cycle, highest first: reset > i_clear > i_false_start > i_valid.
  - i_false_start together with i_valid: the result is discarded and only o_false_count increments.
  - i_clear together with any strobe: the clear wins and the strobe is dropped.
- Accept (i_valid, not overridden) at edge N; the following are visible after edge N+1:
  - o_last = i_ticks.
  - o_best = min(o_best, i_ticks); o_worst = max(o_worst, i_ticks).
  - o_count += 1, saturating at 2^CNT_W - 1.
  - Ring entry [wptr] = i_ticks; wptr increments modulo DEPTH, wrapping DEPTH-1 to 0.
  - Fill level increments, saturating at DEPTH.
  - Running sum (W + log2(DEPTH) bits) = sum + i_ticks - evicted. evicted is the old entry at wptr when the fill level is DEPTH, otherwise 0.
- Average:
  - o_avg = sum >> log2(DEPTH), registered one cycle after the sum, so visible after edge N+2.
  - o_avg_valid rises together with the first o_avg computed from a full window; it stays high until reset or clear.
  - While o_avg_valid = 0, o_avg holds 0.
- Ties: i_ticks equal to o_best or o_worst leaves that output unchanged.
  - An all-ones i_ticks is accepted like any other value.
- False start: o_false_count += 1, saturating. No other state changes.
- Read port:
  - o_rd_ticks is registered with 1-cycle latency and addresses entry (wptr - 1 - i_rd_idx) mod DEPTH.
  - Indices at or beyond the current fill level return 0.
  - A read in the same cycle as an accept returns the pre-write contents.
- No backpressure: the block accepts a strobe on every cycle, including back-to-back cycles.

Decomposition:
- Package result_pkg holds:
  - function clog2;
  - typedef result_t (logic [W-1:0] via a parameterised-width convention);
  - localparam RESULT_NONE = all-ones, the reset sentinel.
- Sub-module result_ring contains the ring memory, write pointer, fill level, running sum and read port.
  - It exposes o_sum and o_full.
  - result_stats keeps last/best/worst, the counters, the average register and strobe arbitration.

Test Plan:
- Reset, then idle 4 cycles -> o_last = o_best = 0xFFFFFFF, o_worst = 0, o_count = 0, o_avg_valid = 0, every i_rd_idx reads 0.
- Accept 500, 300, 700 back-to-back -> o_last = 700, o_best = 300, o_worst = 700, o_count = 3; i_rd_idx 0/1/2 reads 700/300/500, 3 reads 0.
- Accept 100, 200, ..., 800 (DEPTH = 8) -> o_avg_valid rises 2 cycles after the 8th, o_avg = 450. Then accept 900 -> o_avg = 550 (100 evicted), i_rd_idx 7 reads 200.
- i_valid with 50 and i_false_start in the same cycle -> o_false_count = 1, o_last/o_best/o_count unchanged.
- i_clear asserted together with i_valid after 5 results -> all outputs equal the reset values; the next accept of 400 gives o_count = 1, o_best = o_worst = 400.
- Force o_count to 0xFFFF (CNT_W = 16 via a small parameter override, or a long run), then accept once -> o_count stays 0xFFFF, other statistics still update. Also drop i_rst_n for one cycle mid-stream -> reset values after that edge.
